// File: rtl/calc_pkg.sv
// Shared definitions for the calc arbiter: operation codes, FSM states and
// the default datapath width.
package calc_pkg;

    localparam int CALC_WIDTH = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic unit: add, subtract, shift-left and logical
// shift-right by one, each with a carry/borrow/bit-lost flag.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                ovf    = (a < b);
            end
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                ovf    = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                ovf    = a[0];
            end
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_arbiter.sv
// Two-requester round-robin arbiter in front of a shared calc_alu.
// Fixed three-cycle transaction: sample (IDLE), grant (EXEC), complete (DONE).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting; requests sampled here, winner's operands latched
//   EXEC    | grant pulse to winner; ALU result registered at end of cycle
//   DONE    | done pulse to winner; result/ovf valid
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             winner_q, winner_d;
    logic             last_q, last_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic             any_req;
    logic             pick;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    assign any_req = req0 | req1;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick    = req1 & (~req0 | ~last_q);

    calc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_EXEC;
                    winner_d = pick;
                    last_d   = pick;
                    op_d     = pick ? op_e'(op1) : op_e'(op0);
                    a_d      = pick ? a1 : a0;
                    b_d      = pick ? b1 : b0;
                end
            end
            ST_EXEC: begin
                state_d  = ST_DONE;
                result_d = alu_result;
                ovf_d    = alu_ovf;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        done0  = 1'b0;
        done1  = 1'b0;
        busy   = 1'b0;
        result = '0;
        ovf    = 1'b0;
        case (state_q)
            ST_EXEC: begin
                busy = 1'b1;
                gnt0 = ~winner_q;
                gnt1 = winner_q;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done0  = ~winner_q;
                done1  = winner_q;
                result = result_q;
                ovf    = ovf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle with a transaction-level model.
module tb_calc_arbiter;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, ovf, busy;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase 0 idle, 1 granted, 2 completing
    int m_phase, m_win, m_last, m_res, m_ovf;

    calc_arbiter #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .ovf    (ovf),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void calc(input int op, input int a, input int b,
                                 output int r, output int o);
        case (op)
            0: begin r = (a + b) % MOD; o = (a + b >= MOD) ? 1 : 0; end
            1: begin r = (a - b + MOD) % MOD; o = (a < b) ? 1 : 0; end
            2: begin r = (a * 2) % MOD; o = (a >= MOD / 2) ? 1 : 0; end
            default: begin r = a / 2; o = a % 2; end
        endcase
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_win   = 0;
        m_last  = 1;
        m_res   = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_edge();
        if (m_phase == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_win = 1 - m_last;
                else m_win = req1 ? 1 : 0;
                m_last = m_win;
                if (m_win == 0) calc(int'(op0), int'(a0), int'(b0), m_res, m_ovf);
                else            calc(int'(op1), int'(a1), int'(b1), m_res, m_ovf);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endfunction

    task automatic check_outputs();
        check_val("gnt0",  int'(gnt0),  (m_phase == 1 && m_win == 0) ? 1 : 0);
        check_val("gnt1",  int'(gnt1),  (m_phase == 1 && m_win == 1) ? 1 : 0);
        check_val("done0", int'(done0), (m_phase == 2 && m_win == 0) ? 1 : 0);
        check_val("done1", int'(done1), (m_phase == 2 && m_win == 1) ? 1 : 0);
        check_val("busy",  int'(busy),  (m_phase != 0) ? 1 : 0);
        check_val("result", int'(result), (m_phase == 2) ? m_res : 0);
        check_val("ovf",   int'(ovf),   (m_phase == 2) ? m_ovf : 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_gnt0"},  int'(gnt0),   0);
        check_val({tag, "_gnt1"},  int'(gnt1),   0);
        check_val({tag, "_done0"}, int'(done0),  0);
        check_val({tag, "_done1"}, int'(done1),  0);
        check_val({tag, "_busy"},  int'(busy),   0);
        check_val({tag, "_res"},   int'(result), 0);
        check_val({tag, "_ovf"},   int'(ovf),    0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [1:0] op, input int a, input int b);
        if (n == 0) begin
            req0 = 1'b1; op0 = op; a0 = W'(a); b0 = W'(b);
        end else begin
            req1 = 1'b1; op1 = op; a1 = W'(a); b1 = W'(b);
        end
    endtask

    task automatic do_txn(input string tag, input int n, input logic [1:0] op,
                          input int a, input int b, input int er, input int eo);
        set_req(n, op, a, b);
        step();
        check_val({tag, "_gnt"}, int'(n == 0 ? gnt0 : gnt1), 1);
        if (n == 0) req0 = 1'b0; else req1 = 1'b0;
        step();
        check_val({tag, "_done"}, int'(n == 0 ? done0 : done1), 1);
        check_val({tag, "_res"}, int'(result), er);
        check_val({tag, "_ovf"}, int'(ovf), eo);
        step();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0; op1 = 2'd0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #2;
        apply_reset("rst0");

        // basic transactions and boundary values
        do_txn("add32", 0, 2'b00, 3, 2, 5, 0);
        do_txn("add17", 1, 2'b00, 1, 7, 0, 1);
        do_txn("sub01", 0, 2'b01, 0, 1, 7, 1);
        do_txn("shl4",  0, 2'b10, 4, 0, 0, 1);
        do_txn("shr3",  0, 2'b11, 3, 0, 1, 1);
        do_txn("shr6",  0, 2'b11, 6, 0, 3, 0);

        // simultaneous requests after reset: requester 0 first
        apply_reset("rst1");
        set_req(0, 2'b00, 1, 1);
        set_req(1, 2'b00, 2, 2);
        step();
        check_val("rr_gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        step();
        check_val("rr_res0", int'(result), 2);
        step();
        step();
        check_val("rr_gnt1", int'(gnt1), 1);
        req1 = 1'b0;
        step();
        check_val("rr_res1", int'(result), 4);
        step();
        // both held continuously: grants alternate
        set_req(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        set_req(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        for (int i = 0; i < 18; i++) step();
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();

        // request pulsed during EXEC is ignored
        set_req(0, 2'b00, 2, 3);
        step();
        req0 = 1'b0;
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        check_val("ign_done1", int'(done1), 0);
        step();
        step();
        check_val("ign_gnt1", int'(gnt1), 0);

        // reset during EXEC aborts the transaction
        set_req(0, 2'b00, 3, 3);
        step();
        req0 = 1'b0;
        apply_reset("rst_exec");
        step(); step(); step();
        do_txn("post_rst", 0, 2'b00, 1, 2, 3, 0);

        // random traffic: each requester holds until granted
        for (int i = 0; i < 400; i++) begin
            if (!req0 && $urandom_range(0, 2) == 0)
                set_req(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if (!req1 && $urandom_range(0, 2) == 0)
                set_req(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            step();
            if (m_phase == 1 && m_win == 0) req0 = 1'b0;
            if (m_phase == 1 && m_win == 1) req1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: WIDTH, 3, operand/result width in bits.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0, req1  input  1 each  request from requester 0/1.
REQ-005 Port: op0, op1  input  2 each  operation code from requester 0/1.
REQ-006 Port: a0, b0, a1, b1  input  WIDTH each  operands from requester 0/1.
REQ-007 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 Port: done0, done1  output  1 each  one-cycle completion pulse for requester 0/1.
REQ-009 Port: result  output  WIDTH  registered result; valid only while done0 or done1 is high.
REQ-010 Port: ovf  output  1  overflow/bit-lost flag; valid only while done0 or done1 is high.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC, DONE; IDLE->EXEC on any request, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-013 In IDLE with any reqN high at a rising edge, the block SHALL latch that requester's op/a/b, record the winner, and assert gntN for exactly the following cycle.
REQ-014 Requests SHALL be sampled only in IDLE; requests in EXEC or DONE are ignored and not queued.
REQ-015 A requester SHALL hold req, op and operands stable until its gnt; a req still high in IDLE after done starts a new transaction.
REQ-016 Simultaneous req0 and req1 SHALL be resolved round-robin: the requester not granted last wins; after reset requester 0 wins.
REQ-017 On the EXEC->DONE edge the block SHALL register result and ovf and assert doneN (N = winner) for exactly the DONE cycle.
REQ-018 Latency SHALL be fixed: gnt in cycle t+1, done/result in cycle t+2, where t is the sampling edge; minimum 3 cycles per transaction.
REQ-019 op 00 ADD: result = (a+b) mod 2^WIDTH; ovf = carry out of the MSB.
REQ-020 op 01 SUB: result = (a-b) mod 2^WIDTH; ovf = 1 when a < b (borrow).
REQ-021 op 10 SHL by 1: result = a<<1 truncated to WIDTH; ovf = a[WIDTH-1].
REQ-022 op 11 SHR by 1 (logical): result = a>>1; ovf = a[0].
REQ-023 Outside the DONE state, result and ovf SHALL be driven to 0.
REQ-024 Every output SHALL be driven from exactly one always block; no signal has multiple drivers.
REQ-025 All internal registers SHALL be written only from the clocked process; no register is read before assignment.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE; gnt0, gnt1, done0, done1, busy, ovf = 0; result = 0; last-grant = requester 1.
REQ-027 Reset during EXEC or DONE SHALL abort the transaction with no done pulse after release.
REQ-028 After reset deassertion the first sampling edge SHALL behave as IDLE.

Structure
REQ-029 A shared package calc_pkg SHALL hold the op encodings (ADD, SUB, SHL, SHR), the FSM state enum and the default WIDTH.
REQ-030 Arithmetic SHALL live in one combinational sub-module calc_alu (inputs op, a, b; outputs result, ovf), instantiated once and registered in calc_arbiter.

Verification
REQ-031 Reset; req0 ADD a0=3 b0=2 -> gnt0 next cycle, done0 one cycle later, result=5, ovf=0, busy high for 2 cycles.
REQ-032 req1 ADD a1=1 b1=7 -> done1, result=0, ovf=1; req0 SUB a0=0 b0=1 -> result=7, ovf=1.
REQ-033 req0 SHL a0=4 -> result=0, ovf=1; req0 SHR a0=3 -> result=1, ovf=1; req0 SHR a0=6 -> result=3, ovf=0.
REQ-034 Reset, then req0 and req1 held high together with ADD 1+1 and ADD 2+2 -> gnt0/done0 result=2 first, then gnt1/done1 result=4; grants alternate thereafter.
REQ-035 Pulse req1 during EXEC of a req0 transaction -> ignored, no gnt1, no extra done.
REQ-036 Assert reset during EXEC -> all outputs 0 asynchronously, no done pulse after release, next req0 granted normally.
